// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Purpose  : Round-robin arbiter that lets NUM_CORES cores share one
//            fixed-latency data memory port. One access is in flight at a
//            time; each access runs IDLE -> ACCESS -> DONE.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            req/we            - per-core level request and write enable
//            addr/wdata        - per-core address/data, packed core i at
//                                [i*W +: W]
//            grant/done        - one-hot owner and one-cycle completion pulse
//            rdata             - registered read data shared by all cores
//            mem_en/mem_we/mem_addr/mem_wdata - memory command
//            mem_rdata         - memory read data, MEM_LATENCY after mem_en
//            busy              - high whenever an access is in progress
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int NUM_CORES   = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CORES-1:0]             req,
    input  logic [NUM_CORES-1:0]             we,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0]  addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]  wdata,
    output logic [NUM_CORES-1:0]             grant,
    output logic [NUM_CORES-1:0]             done,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             mem_en,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic                             busy
);

    localparam int c_IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    // ACCESS spans counter values 0..MEM_LATENCY, i.e. MEM_LATENCY+1 cycles.
    localparam logic [3:0]         c_LAST_WAIT  = 4'(MEM_LATENCY);
    // Reset value makes core 0 the first candidate of the round-robin scan.
    localparam logic [c_IDX_W-1:0] c_LAST_RESET = c_IDX_W'(NUM_CORES - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [3:0]            r_wait_cnt;
    logic [c_IDX_W-1:0]    r_last;
    logic [NUM_CORES-1:0]  r_grant;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_any_req;
    logic                  w_hit;
    logic [c_IDX_W-1:0]    w_scan_idx;
    logic [c_IDX_W-1:0]    w_sel;
    logic [NUM_CORES-1:0]  w_sel_onehot;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    assign w_any_req = |req;

    // Round-robin scan starting just after the last granted core, with wrap.
    always_comb begin
        w_sel      = r_last;
        w_hit      = 1'b0;
        w_scan_idx = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            w_scan_idx = c_IDX_W'((int'(r_last) + k) % NUM_CORES);
            if (!w_hit && req[w_scan_idx]) begin
                w_hit = 1'b1;
                w_sel = w_scan_idx;
            end
        end
    end

    // Command mux for the selected core (constant part-selects only).
    always_comb begin
        w_sel_onehot = '0;
        w_sel_we     = 1'b0;
        w_sel_addr   = '0;
        w_sel_wdata  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_sel == c_IDX_W'(i)) begin
                w_sel_onehot[i] = 1'b1;
                w_sel_we        = we[i];
                w_sel_addr      = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata     = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. req is only looked at in IDLE, so a started access
    // always runs to completion.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_any_req) w_next_state = c_ST_ACCESS;
            c_ST_ACCESS: if (r_wait_cnt == c_LAST_WAIT) w_next_state = c_ST_DONE;
            c_ST_DONE:   w_next_state = c_ST_IDLE;
            default:     w_next_state = c_ST_IDLE;
        endcase
    end

    // Datapath registers: captured command, owner, wait counter, read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt  <= '0;
            r_last      <= c_LAST_RESET;
            r_grant     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_wait_cnt <= '0;
                    if (w_any_req) begin
                        r_grant     <= w_sel_onehot;
                        r_last      <= w_sel;
                        r_mem_we    <= w_sel_we;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                    end
                end
                c_ST_ACCESS: begin
                    if (r_wait_cnt == c_LAST_WAIT) begin
                        if (!r_mem_we) begin
                            r_rdata <= mem_rdata;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                c_ST_DONE: begin
                    r_grant <= '0;
                end
                default: begin
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Outputs decoded from state; the command fields stay held until the
    // next grant so they are stable through ACCESS and DONE.
    always_comb begin
        mem_en = (r_state == c_ST_ACCESS) && (r_wait_cnt == 4'd0);
        busy   = (r_state != c_ST_IDLE);
        done   = (r_state == c_ST_DONE) ? r_grant : '0;
    end

    assign grant     = r_grant;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rdata     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Purpose  : Scoreboard bench for data_mem_arbiter. Stimulus pushes expected
//            memory commands and completions into queues; a monitor pops and
//            compares whenever mem_en or done is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    grant, done;
    logic [DW-1:0]   rdata;
    logic            mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic            busy;

    data_mem_arbiter #(
        .NUM_CORES  (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .grant     (grant),
        .done      (done),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           cyc;
        logic [N-1:0] vec;
        logic [AW-1:0] a;
        logic          w;
        logic [DW-1:0] d;
    } cmd_t;

    typedef struct {
        int            cyc;
        logic [N-1:0]  vec;
        logic [DW-1:0] rd;
    } done_t;

    cmd_t  cmd_q[$];
    done_t done_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_cmd(input int c, input logic [N-1:0] g, input logic [AW-1:0] a,
                            input logic w, input logic [DW-1:0] d);
        cmd_t e;
        e.cyc = c; e.vec = g; e.a = a; e.w = w; e.d = d;
        cmd_q.push_back(e);
    endtask

    task automatic push_done(input int c, input logic [N-1:0] g, input logic [DW-1:0] rd);
        done_t e;
        e.cyc = c; e.vec = g; e.rd = rd;
        done_q.push_back(e);
    endtask

    // Advance to 1 time unit after the rising edge that starts cycle c.
    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- memory model ----------------
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rv      [LAT];
    logic [DW-1:0] rd_pipe [LAT];

    function automatic logic [DW-1:0] mem_read_val(input logic [AW-1:0] a);
        if (a == 16'h0040)                 return 16'hBEEF;
        else if (wr_valid && a == wr_addr) return wr_data;
        else                               return a ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wr_valid <= 1'b1;
            wr_addr  <= mem_addr;
            wr_data  <= mem_wdata;
        end
        rv[0]      <= mem_en && !mem_we;
        rd_pipe[0] <= mem_read_val(mem_addr);
        for (int k = 1; k < LAT; k++) begin
            rv[k]      <= rv[k-1];
            rd_pipe[k] <= rd_pipe[k-1];
        end
    end

    // Read data is only meaningful in its valid cycle; otherwise a marker.
    assign mem_rdata = (rv[LAT-1] === 1'b1) ? rd_pipe[LAT-1] : 16'hDEAD;

    // ---------------- monitor ----------------
    initial begin
        cmd_t          c;
        done_t         d;
        logic [N-1:0]  prev_done;
        prev_done = '0;
        c.cyc = 0; c.vec = '0; c.a = '0; c.w = 1'b0; c.d = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
                chk("done_within_grant", 32'(done & ~grant), 32'd0);
                chk("busy_vs_grant", 32'(busy), 32'(grant != '0));
                if (prev_done != '0) chk("grant_clear_after_done", 32'(grant), 32'd0);
                if (mem_en) begin
                    if (cmd_q.size() == 0) begin
                        chk("unexpected_mem_en", 32'(mem_en), 32'd0);
                    end else begin
                        c = cmd_q.pop_front();
                        chk("mem_en_cycle", 32'(cyc), 32'(c.cyc));
                        chk("grant", 32'(grant), 32'(c.vec));
                        chk("mem_we", 32'(mem_we), 32'(c.w));
                        chk("mem_addr", 32'(mem_addr), 32'(c.a));
                        chk("mem_wdata", 32'(mem_wdata), 32'(c.d));
                    end
                end else if (grant != '0) begin
                    chk("cmd_hold_addr", 32'(mem_addr), 32'(c.a));
                    chk("cmd_hold_we", 32'(mem_we), 32'(c.w));
                    chk("cmd_hold_grant", 32'(grant), 32'(c.vec));
                end
                if (done != '0) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        d = done_q.pop_front();
                        chk("done_cycle", 32'(cyc), 32'(d.cyc));
                        chk("done", 32'(done), 32'(d.vec));
                        chk("rdata", 32'(rdata), 32'(d.rd));
                    end
                end
            end
            prev_done = done;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Single read, core 2
        t0 = cyc; reset = 1'b0;
        req = 4'b0100; addr[2*AW +: AW] = 16'h0040;
        push_cmd(t0 + 1, 4'b0100, 16'h0040, 1'b0, 16'h0000);
        push_done(t0 + 4, 4'b0100, 16'hBEEF);
        go_to(t0 + 4); req = '0;
        go_to(t0 + 6);

        // Single write, core 1: rdata must keep 0xBEEF
        t0 = cyc;
        req = 4'b0010; we[1] = 1'b1; addr[1*AW +: AW] = 16'h0010; wdata[1*DW +: DW] = 16'h1234;
        push_cmd(t0 + 1, 4'b0010, 16'h0010, 1'b1, 16'h1234);
        push_done(t0 + 4, 4'b0010, 16'hBEEF);
        go_to(t0 + 4); req = '0; we = '0; wdata = '0;
        go_to(t0 + 6);

        // Fairness skip: after core 1, req=1010 -> core 3 then core 1
        t0 = cyc;
        req = 4'b1010; addr[3*AW +: AW] = 16'h0030;
        push_cmd(t0 + 1, 4'b1000, 16'h0030, 1'b0, 16'h0000);
        push_done(t0 + 4, 4'b1000, 16'h5A6A);
        push_cmd(t0 + 6, 4'b0010, 16'h0010, 1'b0, 16'h0000);
        push_done(t0 + 9, 4'b0010, 16'h1234);
        go_to(t0 + 4); req[3] = 1'b0;
        go_to(t0 + 9); req[1] = 1'b0;
        go_to(t0 + 11);

        // Early drop: core 3 releases req during ACCESS
        t0 = cyc;
        req = 4'b1000; addr[3*AW +: AW] = 16'h0077;
        push_cmd(t0 + 1, 4'b1000, 16'h0077, 1'b0, 16'h0000);
        push_done(t0 + 4, 4'b1000, 16'h5A2D);
        go_to(t0 + 2); req = '0;
        go_to(t0 + 6);

        // Contention: reset, then all four held continuously
        reset = 1'b1;
        go_to(cyc + 2);
        @(negedge clk);
        chk("rst2_rdata", 32'(rdata), 32'd0);
        chk("rst2_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        t0 = cyc; reset = 1'b0;
        for (int i = 0; i < N; i++) addr[i*AW +: AW] = 16'h0100 + 16'(i);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [AW-1:0] a;
            logic [N-1:0]  g;
            a = 16'h0100 + 16'(k % N);
            g = 4'b0001 << (k % N);
            push_cmd(t0 + 1 + 5 * k, g, a, 1'b0, 16'h0000);
            push_done(t0 + 4 + 5 * k, g, a ^ 16'h5A5A);
        end
        go_to(t0 + 22); req = '0;
        go_to(t0 + 26);

        // Reset mid-ACCESS of core 0: no done, then core 0 granted again
        t0 = cyc;
        req = 4'b0001; addr[0 +: AW] = 16'h0200;
        push_cmd(t0 + 1, 4'b0001, 16'h0200, 1'b0, 16'h0000);
        go_to(t0 + 2); reset = 1'b1;
        go_to(t0 + 3); reset = 1'b0;
        push_cmd(t0 + 4, 4'b0001, 16'h0200, 1'b0, 16'h0000);
        push_done(t0 + 7, 4'b0001, 16'h585A);
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_grant", 32'(grant), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_mem_en", 32'(mem_en), 32'd0);
        @(posedge clk); #1;
        go_to(t0 + 7); req = '0;
        go_to(t0 + 10);

        chk("cmd_queue_empty", 32'(cmd_q.size()), 32'd0);
        chk("done_queue_empty", 32'(done_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4: number of processor cores sharing data memory.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: memory address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 16: memory data width.
REQ-004 SHALL have parameter MEM_LATENCY, default 2: cycles from the mem_en cycle to mem_rdata valid; legal range 1..15.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port req  input  NUM_CORES  per-core access request, level, held until done.
REQ-008 SHALL have port we  input  NUM_CORES  per-core write enable (1=write, 0=read).
REQ-009 SHALL have port addr  input  NUM_CORES*ADDR_WIDTH  per-core address; core i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 SHALL have port wdata  input  NUM_CORES*DATA_WIDTH  per-core write data, same packing.
REQ-011 SHALL have port grant  output  NUM_CORES  one-hot owner of memory; all-zero when idle.
REQ-012 SHALL have port done  output  NUM_CORES  one-cycle completion pulse to owning core.
REQ-013 SHALL have port rdata  output  DATA_WIDTH  registered read data, shared by all cores.
REQ-014 SHALL have ports mem_en, mem_we (1 bit), mem_addr (ADDR_WIDTH), mem_wdata (DATA_WIDTH)  output  memory command.
REQ-015 SHALL have port mem_rdata  input  DATA_WIDTH  memory read data.
REQ-016 SHALL have port busy  output  1  high in every non-IDLE state.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-018 IDLE: if any req bit is high, SHALL select one core round-robin, register grant, mem_addr, mem_we, and mem_wdata from that core, assert mem_en, and go to ACCESS at the next edge; otherwise SHALL stay in IDLE.
REQ-019 Round-robin SHALL search from (last_granted+1) mod NUM_CORES upward with wrap, and last_granted SHALL update on each grant.
REQ-020 mem_en SHALL be high for exactly the first ACCESS cycle; mem_addr, mem_we, and mem_wdata SHALL hold stable through ACCESS and DONE.
REQ-021 ACCESS SHALL last MEM_LATENCY+1 cycles, counted by a wait counter cleared on entry.
REQ-022 On the last ACCESS cycle, if mem_we=0, SHALL capture mem_rdata into rdata at that edge; on writes rdata SHALL keep its value.
REQ-023 DONE SHALL last one cycle, with done[owner]=1 and grant still held; the next edge SHALL clear grant and return to IDLE.
REQ-024 Latency: req rising in IDLE cycle 0 SHALL give grant/mem_en in cycle 1 and done in cycle MEM_LATENCY+2; back-to-back grants SHALL be MEM_LATENCY+3 cycles apart.
REQ-025 req changes and deassertion during ACCESS/DONE SHALL be ignored; a started access always completes, with no abort.
REQ-026 A new req arriving in the same cycle as DONE SHALL be arbitrated in the following IDLE cycle.
REQ-027 At most one grant bit and one done bit SHALL ever be high; done SHALL equal grant gated by DONE state.

Reset
REQ-028 reset high at a clock edge SHALL force IDLE, wait counter 0, grant 0, done 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, rdata 0, busy 0, last_granted NUM_CORES-1 (core 0 first priority).
REQ-029 reset SHALL take priority over all FSM activity, including mid-ACCESS; the aborted access SHALL produce no done pulse.

Verification
REQ-030 Single read: core 2 req, we=0, addr=0x0040, mem_rdata=0xBEEF at cycle 3 -> grant=0100 and mem_en in cycle 1, rdata=0xBEEF and done=0100 in cycle 4, grant=0 in cycle 5.
REQ-031 Single write: core 1 req, we=1, addr=0x0010, wdata=0x1234 -> mem_en, mem_we=1, mem_addr=0x0010, mem_wdata=0x1234 in cycle 1; done=0010 in cycle 4; rdata unchanged.
REQ-032 Contention: all four req held continuously from reset -> grant order 0,1,2,3,0, with grants at cycles 1, 6, 11, 16, 21.
REQ-033 Fairness skip: req=1010 after core 1 served -> next grant core 3, then core 1.
REQ-034 Reset mid-ACCESS: reset in cycle 2 of core 0 access -> cycle 3 shows IDLE, grant=0, no done pulse; next grant goes to core 0.
REQ-035 Early drop: core 3 deasserts req in cycle 2 -> access completes and done=1000 still pulses in cycle 4.
